// File: rtl/trellis_memory_banked.sv
// trellis_memory_banked: banked survivor-path memory between the ACS array and
// the traceback unit. Decision words are written round-robin into NUM_BANKS
// banks of DEPTH words. Once NUM_BANKS-1 banks are complete, every write also
// reads the traceback bank (wr_bank-1) and the decode bank (wr_bank+1) at
// address DEPTH-1-wr_cnt, so both banks are walked in descending order.
// Optional build macro: TRELLIS_MEM_PARITY_EN adds one even-parity bit per
// stored word and the par_err_tb / par_err_dec outputs.
//
// Handshake: d_in_valid qualifies selection for one cycle with no back-pressure.
// rd_valid is high exactly one cycle after a read was issued, and it qualifies
// rd_addr, d_o_tb and d_o_dec (and the parity flags) on that cycle.
// flush wins over d_in_valid and drops the word presented with it.
module trellis_memory_banked #(
   parameter int SEL_W     = 64,
   parameter int DEPTH     = 32,
   parameter int NUM_BANKS = 4,
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             flush,
   input  logic [SEL_W-1:0] selection,
   input  logic             d_in_valid,
   output logic [BW-1:0]    wr_bank,
   output logic             blk_done,
   output logic [BW-1:0]    fill_cnt,
   output logic             rd_valid,
   output logic [AW-1:0]    rd_addr,
   output logic [SEL_W-1:0] d_o_tb,
   output logic [SEL_W-1:0] d_o_dec
`ifdef TRELLIS_MEM_PARITY_EN
   ,
   output logic             par_err_tb,
   output logic             par_err_dec
`endif
);

`ifdef TRELLIS_MEM_PARITY_EN
   localparam int MW = SEL_W + 1;
`else
   localparam int MW = SEL_W;
`endif

   localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [BW-1:0] wr_bank_q, wr_bank_d;
   logic [BW-1:0] fill_q, fill_d;
   logic          blk_done_q;
   logic          rd_valid_q;
   logic [AW-1:0] rd_addr_q;
   logic [MW-1:0] tb_word_q;
   logic [MW-1:0] dec_word_q;

   logic [MW-1:0] mem [NUM_BANKS][DEPTH];

   logic          wr_en;
   logic          rd_en;
   logic          last_word;
   logic [AW-1:0] rd_addr_c;
   logic [BW-1:0] tb_bank;
   logic [BW-1:0] dec_bank;
   logic [MW-1:0] wr_word;

   // Stored word: data plus, when enabled, a parity bit making the whole word even.
`ifdef TRELLIS_MEM_PARITY_EN
   assign wr_word = {^selection, selection};
`else
   assign wr_word = selection;
`endif

   // Write/read qualification, descending read address and modulo bank neighbours.
   always_comb begin
      wr_en     = d_in_valid & ~flush;
      last_word = (wr_cnt_q == LAST_ADDR);
      rd_en     = wr_en & (fill_q == LAST_BANK);
      rd_addr_c = LAST_ADDR - wr_cnt_q;
      tb_bank   = (wr_bank_q == '0) ? LAST_BANK : wr_bank_q - BW'(1);
      dec_bank  = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BW'(1);
   end

   // Counter next state: flush clears, a valid write advances, a stall holds.
   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      fill_d    = fill_q;
      if (flush) begin
         wr_cnt_d  = '0;
         wr_bank_d = '0;
         fill_d    = '0;
      end else if (d_in_valid) begin
         wr_cnt_d = last_word ? '0 : wr_cnt_q + AW'(1);
         if (last_word) begin
            // The bank after the current one is the decode-bank neighbour.
            wr_bank_d = dec_bank;
            if (fill_q != LAST_BANK) begin
               fill_d = fill_q + BW'(1);
            end
         end
      end
   end

   // Counters, completion pulse and registered read port outputs.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         wr_cnt_q   <= '0;
         wr_bank_q  <= '0;
         fill_q     <= '0;
         blk_done_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         tb_word_q  <= '0;
         dec_word_q <= '0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         wr_bank_q  <= wr_bank_d;
         fill_q     <= fill_d;
         blk_done_q <= wr_en & last_word;
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_addr_q  <= rd_addr_c;
            tb_word_q  <= mem[tb_bank][rd_addr_c];
            dec_word_q <= mem[dec_bank][rd_addr_c];
         end
      end
   end

   // Bank storage write port; the written bank never coincides with a read bank.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank_q][wr_cnt_q] <= wr_word;
      end
   end

   assign wr_bank  = wr_bank_q;
   assign fill_cnt = fill_q;
   assign blk_done = blk_done_q;
   assign rd_valid = rd_valid_q;
   assign rd_addr  = rd_addr_q;
   assign d_o_tb   = tb_word_q[SEL_W-1:0];
   assign d_o_dec  = dec_word_q[SEL_W-1:0];

`ifdef TRELLIS_MEM_PARITY_EN
   // A correctly stored word XORs to zero across data and parity bit.
   assign par_err_tb  = rd_valid_q & (^tb_word_q);
   assign par_err_dec = rd_valid_q & (^dec_word_q);
`endif

endmodule
